// File: rtl/fetch_decode_buf_pkg.sv
// fetch_decode_buf_pkg: shared widths, bubble instruction and the fetch/decode entry type.
package fetch_decode_buf_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pre_pc;
        logic            commit;
    } f2d_entry_t;

    localparam f2d_entry_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pre_pc: '0, commit: 1'b0};
endpackage

// File: rtl/fetch_decode_buf_entry_reg.sv
// f2d_entry_reg: one buffered entry with async reset, load enable and bubble-load (bubble wins).
module f2d_entry_reg
    import fetch_decode_buf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       bubble,
    input  f2d_entry_t d,
    output f2d_entry_t q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      q <= BUBBLE;
        else if (bubble) q <= BUBBLE;
        else if (load)   q <= d;
endmodule

// File: rtl/fetch_decode_buf.sv
// fetch_decode_buf: two-entry elastic fetch->decode buffer (main + skid) with flush.
// Optional F2D_PERF_CNT_EN adds stall and bubble cycle counters.
module fetch_decode_buf
    import fetch_decode_buf_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_i_valid,
    input  logic [ILEN-1:0] fetch_i_instr,
    input  logic [XLEN-1:0] fetch_i_pc,
    input  logic [XLEN-1:0] fetch_i_pre_pc,
    input  logic            fetch_i_commit,
    output logic            f2d_o_ready,
    input  logic            ctrl_i_flush,
    input  logic            decode_i_ready,
    output logic            f2d_o_valid,
    output logic [ILEN-1:0] f2d_o_instr,
    output logic [XLEN-1:0] f2d_o_pc,
    output logic [XLEN-1:0] f2d_o_pre_pc,
    output logic            f2d_o_commit
`ifdef F2D_PERF_CNT_EN
    ,
    output logic [63:0]     f2d_o_stall_cnt,
    output logic [63:0]     f2d_o_bubble_cnt
`endif
);
    logic       main_valid, skid_valid, push, pop, main_load, skid_load;
    f2d_entry_t fetch_entry, main_d, main_q, skid_q;

    assign fetch_entry = '{instr: fetch_i_instr, pc: fetch_i_pc, pre_pc: fetch_i_pre_pc, commit: fetch_i_commit};
    assign push = fetch_i_valid & !skid_valid;
    assign pop  = main_valid & decode_i_ready;
    // push implies an empty skid, so the two main load sources never collide
    assign main_load = (push & (!main_valid | pop)) | (skid_valid & pop);
    assign main_d    = skid_valid ? skid_q : fetch_entry;
    assign skid_load = push & main_valid & !pop;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= !ctrl_i_flush & (push | (main_valid & !pop) | skid_valid);
            skid_valid <= !ctrl_i_flush & (skid_valid ? !pop : skid_load);
        end

    f2d_entry_reg u_main (.clk(clk), .rst_n(rst_n), .load(main_load), .bubble(ctrl_i_flush), .d(main_d), .q(main_q));
    f2d_entry_reg u_skid (.clk(clk), .rst_n(rst_n), .load(skid_load), .bubble(ctrl_i_flush), .d(fetch_entry), .q(skid_q));

    assign f2d_o_ready  = !skid_valid;
    assign f2d_o_valid  = main_valid;
    assign f2d_o_instr  = main_valid ? main_q.instr : NOP_INSTR;
    assign f2d_o_pc     = main_q.pc;
    assign f2d_o_pre_pc = main_q.pre_pc;
    assign f2d_o_commit = main_valid & main_q.commit;

`ifdef F2D_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            f2d_o_stall_cnt  <= '0;
            f2d_o_bubble_cnt <= '0;
        end else begin
            if (fetch_i_valid & !f2d_o_ready) f2d_o_stall_cnt <= f2d_o_stall_cnt + 64'd1;
            if (!f2d_o_valid)                 f2d_o_bubble_cnt <= f2d_o_bubble_cnt + 64'd1;
        end
`endif
endmodule

// File: tb/tb_fetch_decode_buf.sv
// tb_fetch_decode_buf: directed and scoreboard checks for fetch_decode_buf.
module tb_fetch_decode_buf;
    import fetch_decode_buf_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_i_valid = 1'b0;
    logic [ILEN-1:0] fetch_i_instr = '0;
    logic [XLEN-1:0] fetch_i_pc = '0;
    logic [XLEN-1:0] fetch_i_pre_pc = '0;
    logic            fetch_i_commit = 1'b0;
    logic            ctrl_i_flush = 1'b0;
    logic            decode_i_ready = 1'b0;
    logic            f2d_o_ready, f2d_o_valid, f2d_o_commit;
    logic [ILEN-1:0] f2d_o_instr;
    logic [XLEN-1:0] f2d_o_pc, f2d_o_pre_pc;
`ifdef F2D_PERF_CNT_EN
    logic [63:0]     f2d_o_stall_cnt, f2d_o_bubble_cnt;
`endif
    int total = 0;
    int bad = 0;

    fetch_decode_buf dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_i_valid(fetch_i_valid), .fetch_i_instr(fetch_i_instr), .fetch_i_pc(fetch_i_pc),
        .fetch_i_pre_pc(fetch_i_pre_pc), .fetch_i_commit(fetch_i_commit),
        .f2d_o_ready(f2d_o_ready), .ctrl_i_flush(ctrl_i_flush), .decode_i_ready(decode_i_ready),
        .f2d_o_valid(f2d_o_valid), .f2d_o_instr(f2d_o_instr), .f2d_o_pc(f2d_o_pc),
        .f2d_o_pre_pc(f2d_o_pre_pc), .f2d_o_commit(f2d_o_commit)
`ifdef F2D_PERF_CNT_EN
        , .f2d_o_stall_cnt(f2d_o_stall_cnt), .f2d_o_bubble_cnt(f2d_o_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [ILEN-1:0] ins, input logic [XLEN-1:0] pc, input logic c);
        fetch_i_valid  = v;
        fetch_i_instr  = ins;
        fetch_i_pc     = pc;
        fetch_i_pre_pc = pc + 64'd4;
        fetch_i_commit = c;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic rdy, input logic [XLEN-1:0] pc,
                              input logic [ILEN-1:0] ins, input logic c);
        check({tag, ".valid"}, 128'(f2d_o_valid), 128'(v));
        check({tag, ".ready"}, 128'(f2d_o_ready), 128'(rdy));
        check({tag, ".pc"}, 128'(f2d_o_pc), 128'(pc));
        check({tag, ".instr"}, 128'(f2d_o_instr), 128'(ins));
        check({tag, ".commit"}, 128'(f2d_o_commit), 128'(c));
    endtask

    f2d_entry_t sb[$];

    initial begin
        // reset values
        #2;
        expect_out("rst", 1'b0, 1'b1, 64'h0, NOP_INSTR, 1'b0);
        check("rst.pre_pc", 128'(f2d_o_pre_pc), 128'h0);
        tick;
        rst_n = 1'b1;

        // back-to-back with decode ready
        decode_i_ready = 1'b1;
        drv(1'b1, 32'hA000_0001, 64'h8000_0000, 1'b1);
        tick;
        expect_out("b2b0", 1'b1, 1'b1, 64'h8000_0000, 32'hA000_0001, 1'b1);
        check("b2b0.pre_pc", 128'(f2d_o_pre_pc), 128'h8000_0004);
        drv(1'b1, 32'hA000_0002, 64'h8000_0004, 1'b0);
        tick;
        expect_out("b2b1", 1'b1, 1'b1, 64'h8000_0004, 32'hA000_0002, 1'b0);
        drv(1'b1, 32'hA000_0003, 64'h8000_0008, 1'b1);
        tick;
        expect_out("b2b2", 1'b1, 1'b1, 64'h8000_0008, 32'hA000_0003, 1'b1);
        check("b2b2.pre_pc", 128'(f2d_o_pre_pc), 128'h8000_000C);
        drv(1'b0, 32'h0, 64'h0, 1'b0);
        tick;
        expect_out("drain", 1'b0, 1'b1, 64'h8000_0008, NOP_INSTR, 1'b0);

        // back-pressure fills the skid, extra fetch is refused
        decode_i_ready = 1'b0;
        drv(1'b1, 32'hB000_0001, 64'h8000_0000, 1'b1);
        tick;
        expect_out("bp0", 1'b1, 1'b1, 64'h8000_0000, 32'hB000_0001, 1'b1);
        drv(1'b1, 32'hB000_0002, 64'h8000_0004, 1'b0);
        tick;
        expect_out("bp1", 1'b1, 1'b0, 64'h8000_0000, 32'hB000_0001, 1'b1);
        drv(1'b1, 32'hB000_0003, 64'h8000_0020, 1'b1);
        tick;
        expect_out("bp_hold", 1'b1, 1'b0, 64'h8000_0000, 32'hB000_0001, 1'b1);
        drv(1'b0, 32'h0, 64'h0, 1'b0);
        decode_i_ready = 1'b1;
        tick;
        expect_out("bp_pop1", 1'b1, 1'b1, 64'h8000_0004, 32'hB000_0002, 1'b0);
        tick;
        expect_out("bp_pop2", 1'b0, 1'b1, 64'h8000_0004, NOP_INSTR, 1'b0);

        // flush while both entries are full, with a simultaneous push
        decode_i_ready = 1'b0;
        drv(1'b1, 32'hC000_0001, 64'h8000_0000, 1'b1);
        tick;
        drv(1'b1, 32'hC000_0002, 64'h8000_0004, 1'b1);
        tick;
        expect_out("two", 1'b1, 1'b0, 64'h8000_0000, 32'hC000_0001, 1'b1);
        ctrl_i_flush = 1'b1;
        drv(1'b1, 32'hC000_0010, 64'h8000_0010, 1'b1);
        tick;
        ctrl_i_flush = 1'b0;
        expect_out("flush", 1'b0, 1'b1, 64'h0, NOP_INSTR, 1'b0);
        drv(1'b0, 32'h0, 64'h0, 1'b0);
        decode_i_ready = 1'b1;
        tick;
        expect_out("post_flush", 1'b0, 1'b1, 64'h0, NOP_INSTR, 1'b0);

        // async reset mid-cycle with both entries full
        decode_i_ready = 1'b0;
        drv(1'b1, 32'hD000_0001, 64'h8000_0040, 1'b1);
        tick;
        drv(1'b1, 32'hD000_0002, 64'h8000_0044, 1'b1);
        tick;
        drv(1'b0, 32'h0, 64'h0, 1'b0);
        expect_out("pre_arst", 1'b1, 1'b0, 64'h8000_0040, 32'hD000_0001, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        expect_out("arst", 1'b0, 1'b1, 64'h0, NOP_INSTR, 1'b0);
        check("arst.pre_pc", 128'(f2d_o_pre_pc), 128'h0);
        tick;
        rst_n = 1'b1;

        // random valid/ready against a queue scoreboard
        for (int n = 0; n < 10000; n++) begin
            f2d_entry_t e;
            logic fv, dr, do_push, do_pop;
            check("rnd.valid", 128'(f2d_o_valid), 128'(sb.size() > 0));
            check("rnd.ready", 128'(f2d_o_ready), 128'(sb.size() < 2));
            if (sb.size() > 0) begin
                check("rnd.instr", 128'(f2d_o_instr), 128'(sb[0].instr));
                check("rnd.pc", 128'(f2d_o_pc), 128'(sb[0].pc));
                check("rnd.pre_pc", 128'(f2d_o_pre_pc), 128'(sb[0].pre_pc));
                check("rnd.commit", 128'(f2d_o_commit), 128'(sb[0].commit));
            end
            fv = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            e.instr  = $urandom;
            e.pc     = {$urandom, $urandom};
            e.pre_pc = {$urandom, $urandom};
            e.commit = 1'($urandom_range(0, 1));
            fetch_i_valid  = fv;
            fetch_i_instr  = e.instr;
            fetch_i_pc     = e.pc;
            fetch_i_pre_pc = e.pre_pc;
            fetch_i_commit = e.commit;
            decode_i_ready = dr;
            do_push = fv && sb.size() < 2;
            do_pop  = dr && sb.size() > 0;
            tick;
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(e);
        end

`ifdef F2D_PERF_CNT_EN
        // perf counters: 3 bubble cycles then 5 stalled cycles
        drv(1'b0, 32'h0, 64'h0, 1'b0);
        decode_i_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("perf.rst_stall", 128'(f2d_o_stall_cnt), 128'h0);
        check("perf.rst_bubble", 128'(f2d_o_bubble_cnt), 128'h0);
        tick;
        rst_n = 1'b1;
        tick;
        tick;
        drv(1'b1, 32'hE000_0001, 64'h8000_0000, 1'b0);
        tick;
        drv(1'b1, 32'hE000_0002, 64'h8000_0004, 1'b0);
        tick;
        drv(1'b1, 32'hE000_0003, 64'h8000_0008, 1'b0);
        for (int k = 0; k < 5; k++) tick;
        check("perf.stall", 128'(f2d_o_stall_cnt), 128'd5);
        check("perf.bubble", 128'(f2d_o_bubble_cnt), 128'd3);
        drv(1'b0, 32'h0, 64'h0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
